mem_trace_fifo: RTL

MEM_TRACE_FIFO -- requirements
Module: mem_trace_fifo

---
 rtl/mem_trace_fifo.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_trace_fifo.sv
// Memory-access trace FIFO: captures completed bus accesses with a sequence
// number and presents them to a consumer through a valid/ready head port.
// Latency: a capture is visible at the head one cycle after its event cycle,
// with no bypass. Backpressure: when the FIFO is full and the head is not
// popped in the same cycle, the capture is dropped. It still consumes a
// sequence number, bumps the saturating drop_cnt and sets the sticky ovf.
//
// Ports:
//   clk, reset          - single clock; synchronous active-high reset
//   cap_en, bus_stb     - capture event when both are high
//   bus_we/addr/data    - access fields sampled in the event cycle
//   tr_valid/tr_ready   - head handshake; pop = tr_valid & tr_ready
//   tr_addr/data/we/seq - head entry fields
//   level               - current occupancy (0..DEPTH)
//   drop_cnt, ovf       - drop statistics; clr_ovf clears both
module mem_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cap_en,
  input  logic                       bus_stb,
  input  logic [3:0]                 bus_we,
  input  logic [AW-1:0]              bus_addr,
  input  logic [DW-1:0]              bus_data,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [AW-1:0]              tr_addr,
  output logic [DW-1:0]              tr_data,
  output logic [3:0]                 tr_we,
  output logic [15:0]                tr_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_cnt,
  output logic                       ovf,
  input  logic                       clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    we;
    logic [15:0]   seq;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [15:0]   seq_cnt;
  entry_t        head;

  logic cap;
  logic pop;
  logic push;
  logic drop;

  assign cap  = bus_stb & cap_en;
  assign pop  = tr_valid & tr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = cap & ((level != FULL) | pop);
  assign drop = cap & ~push;

  assign tr_valid = (level != '0);
  assign head     = mem[rd_ptr];
  assign tr_addr  = head.addr;
  assign tr_data  = head.data;
  assign tr_we    = head.we;
  assign tr_seq   = head.seq;

  // Storage carries no reset; stale slots are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{addr: bus_addr, data: bus_data, we: bus_we, seq: seq_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      // Pointers are exactly PW bits wide, so they wrap modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      // Every capture event spends a sequence number, stored or dropped.
      if (cap) seq_cnt <= seq_cnt + 16'd1;

      // A drop in the same cycle as clr_ovf wins: the count restarts at 1.
      if (drop) begin
        ovf <= 1'b1;
        if (clr_ovf)                   drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (clr_ovf) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule
